// File: rtl/poly_root_pkg.sv
// Shared types and elaboration helpers for the poly_root_unit slice.
package poly_root_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SUM  = 2'd2
  } state_t;

  localparam logic MODE_CBRT = 1'b0;
  localparam logic MODE_SQRT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction
endpackage

// File: rtl/poly_root_if.sv
// Start/busy handshake bundle between the lab datapath and poly_root_unit.
interface poly_root_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 12
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             start;
  logic [OUT_W-1:0] out;
  logic             ovf;
  logic             done;
  logic             busy;

  modport master (output a, b, mode, start, input out, ovf, done, busy);
  modport slave  (input a, b, mode, start, output out, ovf, done, busy);
endinterface

// File: rtl/poly_root_unit_root_iter.sv
// Digit-by-digit integer cube/square root engine, one result bit per step,
// consuming the operand MSB group first.
module root_iter import poly_root_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int ROOT_W = (WIDTH + 1) / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic [WIDTH-1:0]  x,
  input  logic              step,
  output logic [ROOT_W-1:0] root,
  output logic              finished
);
  localparam int CI = (WIDTH + 2) / 3;
  localparam int SI = (WIDTH + 1) / 2;
  localparam int XW = max2(3 * CI, 2 * SI);
  localparam int RW = 2 * XW + 8;
  localparam int IW = clog2(SI + 1) + 1;

  logic [XW-1:0]     xs;
  logic [ROOT_W-1:0] y;
  logic [RW-1:0]     r, rn, t, y2;
  logic [IW-1:0]     cnt, iter;
  logic              md, ge;

  assign root     = y;
  assign finished = (cnt == iter);

  // Trial subtrahend for appending a 1 bit: (2y+1)^k - (2y)^k.
  always_comb begin
    y2 = RW'(y) << 1;
    if (md == MODE_CBRT) begin
      rn = (r << 3) | RW'(xs[XW-1 -: 3]);
      t  = RW'(3) * y2 * (y2 + RW'(1)) + RW'(1);
    end else begin
      rn = (r << 2) | RW'(xs[XW-1 -: 2]);
      t  = (y2 << 1) | RW'(1);
    end
    ge = (rn >= t);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xs <= '0; y <= '0; r <= '0; cnt <= '0; iter <= '0; md <= MODE_CBRT;
    end else if (load) begin
      md   <= mode;
      xs   <= (mode == MODE_CBRT) ? (XW'(x) << (XW - 3 * CI)) : (XW'(x) << (XW - 2 * SI));
      y    <= '0;
      r    <= '0;
      cnt  <= '0;
      iter <= (mode == MODE_CBRT) ? IW'(CI) : IW'(SI);
    end else if (step && !finished) begin
      xs  <= (md == MODE_CBRT) ? (xs << 3) : (xs << 2);
      r   <= ge ? (rn - t) : rn;
      y   <= ROOT_W'({y, ge});
      cnt <= cnt + IW'(1);
    end
  end
endmodule

// File: rtl/poly_root_unit.sv
// out = COEF_A*a + COEF_B*root(b): serial shift-add multiply alongside the
// root engine, then one saturating add cycle.
module poly_root_unit import poly_root_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int COEF_A = 3,
  parameter int COEF_W = 4,
  parameter int COEF_B = 2,
  parameter int OUT_W  = 12
) (
  input logic clk,
  input logic rst,
  poly_root_if.slave bus
);
  localparam int CI = (WIDTH + 2) / 3;
  localparam int SI = (WIDTH + 1) / 2;
  localparam int NC = max2(COEF_W, CI);
  localparam int NS = max2(COEF_W, SI);
  localparam int CW = clog2(max2(NC, NS) + 1) + 1;
  localparam int PW = WIDTH + COEF_W;
  localparam int SH = clog2(COEF_B);
  // Wide enough that the product never truncates, even when OUT_W < PW.
  localparam int SW = max2(max2(PW, SI + SH), OUT_W) + 1;
  localparam logic [COEF_W-1:0] CA = COEF_W'(COEF_A);

  state_t            state;
  logic [PW-1:0]     mcand, acc;
  logic [COEF_W-1:0] coef_q;
  logic [CW-1:0]     cnt, last_q;
  logic [SI-1:0]     root;
  logic              root_done, accept, sat;
  logic [SW-1:0]     sum;

  assign accept = (state == S_IDLE) && bus.start;
  assign sum    = SW'(acc) + (SW'(root) << SH);
  assign sat    = |sum[SW-1:OUT_W];

  root_iter #(.WIDTH(WIDTH), .ROOT_W(SI)) u_root (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .mode     (bus.mode),
    .x        (bus.b),
    .step     ((state == S_RUN) && !root_done),
    .root     (root),
    .finished (root_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bus.out  <= '0;
      bus.ovf  <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      coef_q   <= '0;
      cnt      <= '0;
      last_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mcand    <= PW'(bus.a);
            acc      <= '0;
            coef_q   <= CA;
            cnt      <= '0;
            last_q   <= (bus.mode == MODE_SQRT) ? CW'(NS - 1) : CW'(NC - 1);
            bus.ovf  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          // coef_q drains to zero after COEF_W steps, idling the multiplier.
          if (coef_q[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          coef_q <= coef_q >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == last_q) state <= S_SUM;
        end
        S_SUM: begin
          bus.out  <= sat ? '1 : sum[OUT_W-1:0];
          bus.ovf  <= sat;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_root_unit.sv
// Bench for poly_root_unit: two instances (OUT_W 12 and 9) driven in lockstep.
module tb_poly_root_unit;
  import poly_root_pkg::*;

  localparam int W   = 8;
  localparam int OW0 = 12;
  localparam int OW1 = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  poly_root_if #(.WIDTH(W), .OUT_W(OW0)) bus0 ();
  poly_root_if #(.WIDTH(W), .OUT_W(OW1)) bus1 ();

  poly_root_unit #(.WIDTH(W), .COEF_A(3), .COEF_W(4), .COEF_B(2), .OUT_W(OW0)) u0 (
    .clk(clk), .rst(rst), .bus(bus0));
  poly_root_unit #(.WIDTH(W), .COEF_A(3), .COEF_W(4), .COEF_B(2), .OUT_W(OW1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int a; int b; bit m;
    int o0; bit v0;
    int o1; bit v1;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: smallest-exceeding search gives the floor root directly.
  function automatic int ref_root(input int b, input bit m);
    int r;
    r = 0;
    if (m == MODE_CBRT) while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    else                while ((r + 1) * (r + 1) <= b) r++;
    return r;
  endfunction

  function automatic int ref_sum(input int a, input int b, input bit m);
    return 3 * a + 2 * ref_root(b, m);
  endfunction

  function automatic int sat_val(input int s, input int ow);
    return (s >= (1 << ow)) ? (1 << ow) - 1 : s;
  endfunction

  function automatic int sat_flag(input int s, input int ow);
    return (s >= (1 << ow)) ? 1 : 0;
  endfunction

  task automatic drive(input int a, input int b, input bit m, input bit s);
    bus0.a = a[W-1:0]; bus0.b = b[W-1:0]; bus0.mode = m; bus0.start = s;
    bus1.a = a[W-1:0]; bus1.b = b[W-1:0]; bus1.mode = m; bus1.start = s;
  endtask

  task automatic set_start(input bit s);
    bus0.start = s;
    bus1.start = s;
  endtask

  // One isolated operation; ends on the negedge where done should be high.
  task automatic op(input int a, input int b, input bit m, input string tag);
    int nb;
    @(negedge clk); drive(a, b, m, 1'b1);
    @(negedge clk); set_start(1'b0);
    nb = 0;
    while (bus0.busy && nb < 30) begin
      nb++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(nb), 32'd5);
    chk({tag, " done"}, 32'(bus0.done), 32'd1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus0.done) begin ok = 1'b1; break; end
    end
  endtask

  // start held high; next operands are presented during each done cycle.
  task automatic sweep(input bit m);
    int cur_a, cur_b, s;
    bit ok;
    @(negedge clk);
    cur_a = int'($urandom_range(0, 255));
    cur_b = 0;
    drive(cur_a, cur_b, m, 1'b1);
    for (int b = 0; b < 256; b++) begin
      wait_done(ok);
      chk("b2b done seen", 32'(ok), 32'd1);
      s = ref_sum(cur_a, cur_b, m);
      chk("b2b out0", 32'(bus0.out), 32'(sat_val(s, OW0)));
      chk("b2b ovf0", 32'(bus0.ovf), 32'(sat_flag(s, OW0)));
      chk("b2b out1", 32'(bus1.out), 32'(sat_val(s, OW1)));
      chk("b2b ovf1", 32'(bus1.ovf), 32'(sat_flag(s, OW1)));
      if (b < 255) begin
        cur_a = int'($urandom_range(0, 255));
        cur_b = b + 1;
        drive(cur_a, cur_b, m, 1'b1);
        @(negedge clk);
        chk("b2b busy after done", 32'(bus0.busy), 32'd1);
      end else begin
        set_start(1'b0);
      end
    end
  endtask

  initial begin
    int dn;
    logic [OW0-1:0] o;

    tbl[0]  = '{10, 27, 0, 36, 0, 36, 0};
    tbl[1]  = '{255, 255, 0, 777, 0, 511, 1};
    tbl[2]  = '{1, 1, 0, 5, 0, 5, 0};
    tbl[3]  = '{0, 200, 1, 28, 0, 28, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 5, 0, 5, 0};
    tbl[7]  = '{255, 255, 1, 795, 0, 511, 1};
    tbl[8]  = '{100, 64, 0, 308, 0, 308, 0};
    tbl[9]  = '{170, 0, 1, 510, 0, 510, 0};
    tbl[10] = '{171, 0, 1, 513, 0, 511, 1};
    tbl[11] = '{0, 216, 0, 12, 0, 12, 0};
    tbl[12] = '{0, 215, 0, 10, 0, 10, 0};

    drive(0, 0, MODE_CBRT, 1'b0);
    #1;
    chk("reset out0", 32'(bus0.out), 32'd0);
    chk("reset ovf0", 32'(bus0.ovf), 32'd0);
    chk("reset done0", 32'(bus0.done), 32'd0);
    chk("reset busy0", 32'(bus0.busy), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      op(tbl[i].a, tbl[i].b, tbl[i].m, "tbl");
      chk("tbl out0", 32'(bus0.out), 32'(tbl[i].o0));
      chk("tbl ovf0", 32'(bus0.ovf), 32'(tbl[i].v0));
      chk("tbl out1", 32'(bus1.out), 32'(tbl[i].o1));
      chk("tbl ovf1", 32'(bus1.ovf), 32'(tbl[i].v1));
      @(negedge clk);
      chk("tbl done pulse width", 32'(bus0.done), 32'd0);
    end

    // start pulsed during RUN must be ignored
    @(negedge clk); drive(10, 27, MODE_CBRT, 1'b1);
    @(negedge clk); set_start(1'b0);
    @(negedge clk); drive(255, 255, MODE_SQRT, 1'b1);
    @(negedge clk); set_start(1'b0);
    dn = 0; o = '0;
    for (int c = 0; c < 12; c++) begin
      if (bus0.done) begin dn++; o = bus0.out; end
      @(negedge clk);
    end
    chk("ignored start done count", 32'(dn), 32'd1);
    chk("ignored start out0", 32'(o), 32'd36);
    chk("ignored start idle", 32'(bus0.busy), 32'd0);

    // asynchronous reset in the second RUN cycle
    @(negedge clk); drive(255, 255, MODE_CBRT, 1'b1);
    @(negedge clk); set_start(1'b0);
    @(negedge clk);
    #1;
    chk("busy before rst", 32'(bus0.busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async rst out0", 32'(bus0.out), 32'd0);
    chk("async rst out1", 32'(bus1.out), 32'd0);
    chk("async rst busy0", 32'(bus0.busy), 32'd0);
    chk("async rst done0", 32'(bus0.done), 32'd0);
    chk("async rst ovf0", 32'(bus0.ovf), 32'd0);
    @(negedge clk); rst = 1'b1;
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus0.done) dn++;
    end
    chk("no done after rst", 32'(dn), 32'd0);
    op(1, 1, MODE_CBRT, "post rst");
    chk("post rst out0", 32'(bus0.out), 32'd5);

    sweep(MODE_CBRT);
    sweep(MODE_SQRT);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
